// File: rtl/fp32_accum.sv
// fp32_accum: sequential fp32 accumulator for fmul products.
// Each accepted element takes ALIGN -> ADD -> NORM -> ROUND (4 cycles)
// through one shared adder. The element flagged last parks the sum in DONE
// until the downstream stage takes it.
module fp32_accum #(
    parameter int BIT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIT_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [BIT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    state_t            state_q, state_d;
    logic [31:0]       acc_q, b_q, bypv_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              nan_q, last_q, sg_q, sub_q, byp_q, bnan_q, nz_q;
    logic signed [9:0] ea_q, ne_q;
    logic [26:0]       ma_q, mb_q, nm_q;
    logic [27:0]       sum_q;

    // ALIGN signals
    logic [7:0]  a_e, b_e, hi_e, lo_e, dexp;
    logic [23:0] a_m, b_m, hi_m, lo_m;
    logic        a_big, hi_s, a_inf, b_inf, a_nan, b_nan, al_nan, al_byp;
    logic [31:0] al_bypv;
    logic [53:0] sh;
    logic [26:0] lo_sh;
    // NORM signals
    logic [4:0]        lz;
    logic [26:0]       nm_d;
    logic signed [9:0] ne_d;
    // ROUND signals
    logic              rup;
    logic [24:0]       rm;
    logic signed [9:0] re;
    logic [22:0]       frac;
    logic [31:0]       acc_d;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = acc_q;
    assign out_count = cnt_q;

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = last_q ? S_DONE : S_IDLE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // unpack, order by magnitude, align the smaller operand; detect specials
    always_comb begin
        a_e   = acc_q[30:23];
        b_e   = b_q[30:23];
        a_m   = (a_e == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
        b_m   = (b_e == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
        a_big = {a_e, a_m[22:0]} >= {b_e, b_m[22:0]};
        hi_e  = a_big ? a_e : b_e;
        hi_m  = a_big ? a_m : b_m;
        hi_s  = a_big ? acc_q[31] : b_q[31];
        lo_e  = a_big ? b_e : a_e;
        lo_m  = a_big ? b_m : a_m;
        dexp  = hi_e - lo_e;
        sh    = {lo_m, 3'b000, 27'd0} >> dexp;
        // beyond 27 positions everything lands in sticky
        if (dexp >= 8'd27) lo_sh = {26'd0, |lo_m};
        else               lo_sh = {sh[53:28], sh[27] | (|sh[26:0])};

        a_inf   = (a_e == 8'hFF) && (acc_q[22:0] == 23'd0);
        b_inf   = (b_e == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan   = (a_e == 8'hFF) && (acc_q[22:0] != 23'd0);
        b_nan   = (b_e == 8'hFF) && (b_q[22:0] != 23'd0);
        al_nan  = nan_q | a_nan | b_nan | (a_inf & b_inf & (acc_q[31] ^ b_q[31]));
        al_byp  = al_nan | a_inf | b_inf;
        al_bypv = al_nan ? QNAN : (a_inf ? acc_q : b_q);
    end

    // carry shifts right once; otherwise leading-zero count and shift left
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum_q[i]) lz = 5'(26 - i);
        if (sum_q[27]) begin
            nm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
            ne_d = ea_q + 10'sd1;
        end else begin
            nm_d = sum_q[26:0] << lz;
            ne_d = ea_q - $signed({5'd0, lz});
        end
    end

    // round-to-nearest-even and pack, with flush/overflow/special handling
    always_comb begin
        rup  = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
        rm   = {1'b0, nm_q[26:3]} + {24'd0, rup};
        re   = rm[24] ? ne_q + 10'sd1 : ne_q;
        frac = rm[24] ? rm[23:1] : rm[22:0];
        if (byp_q)                   acc_d = bypv_q;
        else if (nz_q || re <= 10'sd0) acc_d = 32'd0;
        else if (re >= 10'sd255)     acc_d = {sg_q, 8'hFF, 23'd0};
        else                         acc_d = {sg_q, re[7:0], frac};
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // datapath registers, each stage loading its own slice of the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 32'd0; cnt_q <= '0; nan_q <= 1'b0;
            b_q <= 32'd0; last_q <= 1'b0;
            sg_q <= 1'b0; sub_q <= 1'b0; byp_q <= 1'b0; bnan_q <= 1'b0; bypv_q <= 32'd0;
            ea_q <= '0; ma_q <= '0; mb_q <= '0; sum_q <= '0;
            nm_q <= '0; ne_q <= '0; nz_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    b_q    <= in_data;
                    last_q <= in_last;
                end
                S_ALIGN: begin
                    sg_q   <= hi_s;
                    sub_q  <= acc_q[31] ^ b_q[31];
                    ea_q   <= $signed({2'b00, hi_e});
                    ma_q   <= {hi_m, 3'b000};
                    mb_q   <= lo_sh;
                    byp_q  <= al_byp;
                    bnan_q <= al_nan;
                    bypv_q <= al_bypv;
                end
                S_ADD: sum_q <= sub_q ? {1'b0, ma_q} - {1'b0, mb_q}
                                      : {1'b0, ma_q} + {1'b0, mb_q};
                S_NORM: begin
                    nm_q <= nm_d;
                    ne_q <= ne_d;
                    nz_q <= (sum_q == 28'd0);
                end
                S_ROUND: begin
                    acc_q <= acc_d;
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    if (bnan_q) nan_q <= 1'b1;
                end
                S_DONE: if (out_ready) begin
                    acc_q <= 32'd0;
                    cnt_q <= '0;
                    nan_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accum.sv
// tb_fp32_accum: directed and randomized checks of fp32_accum against a
// real-arithmetic reference model.
module tb_fp32_accum;

    logic        clk, rst_n;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    fp32_accum #(.BIT_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fp32 bits -> real (exp=0 treated as zero)
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // real -> fp32 bits with round-to-nearest-even (normal range only)
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] k;
        logic        up;
        int          e;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        m  = {1'b1, d[51:0]};
        up = m[28] && ((|m[27:0]) || m[29]);
        k  = {1'b0, m[52:29]} + {24'd0, up};
        e  = int'(d[62:52]) - 1023 + 127;
        if (k[24]) begin e = e + 1; k = k >> 1; end
        return {d[63], 8'(e), k[22:0]};
    endfunction

    // present one element and return at the falling edge after its accept
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // wait for a result, capture it, then take it with a one-cycle out_ready
    task automatic get(output logic [31:0] d, output logic [15:0] c);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL get_timeout: out_valid still 0 after %0d cycles, required 1", n);
        end
        d = out_data; c = out_count;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 32'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b data=%h cnt=%0d, required 1 0 00000000 0",
                     in_ready, out_valid, out_data, out_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [31:0] d; logic [15:0] c; int n;
        send(32'h42280000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        total++;
        if (n !== 4) begin bad++; $display("FAIL single_latency: got %0d cycles, required 4", n); end
        get(d, c);
        total++;
        if (d !== 32'h42280000 || c !== 16'd1) begin
            bad++; $display("FAIL single_value: got %h/%0d, required 42280000/1", d, c);
        end
    endtask

    task automatic test_seq;
        logic [31:0] v [3];
        logic [31:0] d; logic [15:0] c; int n;
        v[0] = 32'h3F800000; v[1] = 32'h40000000; v[2] = 32'h40400000;
        for (int i = 0; i < 3; i++) begin
            send(v[i], i == 2);
            n = 0;
            while (!in_ready && n < 20) begin n++; @(negedge clk); end
            if (i == 2) n = n; // last element: in_ready stays low in DONE
            if (i < 2) begin
                total++;
                if (n !== 4) begin bad++; $display("FAIL seq_busy%0d: in_ready low %0d cycles, required 4", i, n); end
            end
        end
        get(d, c);
        total++;
        if (d !== 32'h40C00000 || c !== 16'd3) begin
            bad++; $display("FAIL seq_value: got %h/%0d, required 40C00000/3", d, c);
        end
    endtask

    task automatic test_round;
        logic [31:0] d; logic [15:0] c;
        send(32'h3F800000, 1'b0); send(32'h33800000, 1'b1); get(d, c);
        total++;
        if (d !== 32'h3F800000) begin bad++; $display("FAIL round_tie: got %h, required 3F800000", d); end
        send(32'h3F800000, 1'b0); send(32'h33C00000, 1'b1); get(d, c);
        total++;
        if (d !== 32'h3F800001) begin bad++; $display("FAIL round_up: got %h, required 3F800001", d); end
    endtask

    task automatic test_specials;
        logic [31:0] a [3], b [3], r [3];
        logic [31:0] d; logic [15:0] c;
        a[0] = 32'h42280000; b[0] = 32'hC2280000; r[0] = 32'h00000000;
        a[1] = 32'h7F800000; b[1] = 32'hFF800000; r[1] = 32'h7FC00000;
        a[2] = 32'h7F7FFFFF; b[2] = 32'h7F7FFFFF; r[2] = 32'h7F800000;
        for (int i = 0; i < 3; i++) begin
            send(a[i], 1'b0); send(b[i], 1'b1); get(d, c);
            total++;
            if (d !== r[i] || c !== 16'd2) begin
                bad++; $display("FAIL special%0d: got %h/%0d, required %h/2", i, d, c, r[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic [15:0] c; int n;
        send(32'h40400000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin n++; @(negedge clk); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 32'h40400000, 16'd1}) begin
                bad++;
                $display("FAIL hold%0d: vld=%b rdy=%b data=%h cnt=%0d, required 1 0 40400000 1",
                         i, out_valid, in_ready, out_data, out_count);
            end
            @(negedge clk);
        end
        get(d, c);
        send(32'h40000000, 1'b1); get(d, c);
        total++;
        if (d !== 32'h40000000 || c !== 16'd1) begin
            bad++; $display("FAIL after_hold: got %h/%0d, required 40000000/1", d, c);
        end
    endtask

    task automatic test_random;
        logic [31:0] x, model, d; logic [15:0] c; int len;
        for (int v = 0; v < 20; v++) begin
            len = $urandom_range(1, 6);
            model = 32'd0;
            for (int k = 0; k < len; k++) begin
                // exponents 120..134 keep every partial sum exact in a double
                x = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
                model = r2f(f2r(model) + f2r(x));
                send(x, k == len - 1);
            end
            get(d, c);
            total++;
            if (d !== model || c !== 16'(len)) begin
                bad++; $display("FAIL random%0d: got %h/%0d, required %h/%0d", v, d, c, model, len);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic [15:0] c;
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        @(posedge clk);  // now in ADD
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, out_data, out_count} !== {1'b1, 1'b0, 32'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset_mid: rdy=%b vld=%b data=%h cnt=%0d, required 1 0 00000000 0",
                     in_ready, out_valid, out_data, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h3F800000, 1'b1); get(d, c);
        total++;
        if (d !== 32'h3F800000 || c !== 16'd1) begin
            bad++; $display("FAIL after_reset: got %h/%0d, required 3F800000/1", d, c);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_seq;
        test_round;
        test_specials;
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
